// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parameterised VGA raster timing and test-pattern source.
//
// Divides clk down to a pixel enable, runs horizontal/vertical raster
// counters, and drives sync pulses, a data-enable, pixel coordinates and
// RGB565 colour from a built-in pattern generator. Every output is a
// register that loads on the clk edge that consumes a pixel enable, so it
// shows the counter position one clk late and holds between pixel enables.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   mode        pattern: 0 black, 1 colour bars, 2 checkerboard, 3 solid
//   solid_rgb   RGB565 colour used by mode 3
//   Hsync/Vsync sync pulses, asserted level set by HS_POL / VS_POL
//   Red/Green/Blue  colour, forced to 0 outside the active region
//   de          active-region flag
//   x, y        current pixel column / line
//   frame_start one-clk pulse with the output update for pixel (0,0)
//
// Optional build macro VGA_BORDER_EN: when defined, the outermost active
// row/column is painted white on top of whatever pattern is selected.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CHK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_rgb,
    output logic        Hsync,
    output logic        Vsync,
    output logic [4:0]  Red,
    output logic [5:0]  Green,
    output logic [4:0]  Blue,
    output logic        de,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic pe;

    generate
        if (CLK_DIV > 1) begin : g_div
            localparam int DW = $clog2(CLK_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
            logic [DW-1:0] div;

            always_ff @(posedge clk) begin
                if (rst || div == DIV_LAST) div <= '0;
                else                         div <= div + 1'b1;
            end

            assign pe = (div == DIV_LAST);
        end else begin : g_nodiv
            assign pe = 1'b1;
        end
    endgenerate

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Colour-bar index: counts BAR_W active pixels per bar instead of
    // dividing h_cnt. Saturating at 7 lets the H_ACTIVE % 8 leftover
    // pixels extend the last bar.
    logic [10:0] bar_px;
    logic [2:0]  bar_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (pe) begin
            if (h_cnt == H_LAST) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (h_cnt < H_ACT) begin
                if (bar_px == BAR_LAST) begin
                    bar_px <= '0;
                    if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_px <= bar_px + 1'b1;
                end
            end
        end
    end

    // Pattern selection is frozen per frame. The first pixel of the frame
    // already uses the freshly sampled mode so the whole frame is uniform.
    logic        first_px;
    logic [1:0]  mode_q, mode_eff;
    logic [15:0] solid_q, solid_eff;

    assign first_px  = (h_cnt == '0) && (v_cnt == '0);
    assign mode_eff  = first_px ? mode      : mode_q;
    assign solid_eff = first_px ? solid_rgb : solid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= '0;
            solid_q <= '0;
        end else if (pe && first_px) begin
            mode_q  <= mode;
            solid_q <= solid_rgb;
        end
    end

    logic        de_n, hs_n, vs_n;
    logic [15:0] rgb_n;

    assign de_n = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_n = (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
    assign vs_n = (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;

    always_comb begin
        rgb_n = '0;
        if (de_n) begin
            case (mode_eff)
                2'd1: begin
                    case (bar_idx)
                        3'd0: rgb_n = 16'hFFFF;  // white
                        3'd1: rgb_n = 16'hFFE0;  // yellow
                        3'd2: rgb_n = 16'h07FF;  // cyan
                        3'd3: rgb_n = 16'h07E0;  // green
                        3'd4: rgb_n = 16'hF81F;  // magenta
                        3'd5: rgb_n = 16'hF800;  // red
                        3'd6: rgb_n = 16'h001F;  // blue
                        3'd7: rgb_n = 16'h0000;  // black
                    endcase
                end
                2'd2: if (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) rgb_n = 16'hFFFF;
                2'd3: rgb_n = solid_eff;
                2'd0: rgb_n = 16'h0000;
            endcase
        end
`ifdef VGA_BORDER_EN
        if (de_n && (h_cnt == '0 || h_cnt == H_ACT - 11'd1 ||
                     v_cnt == '0 || v_cnt == V_ACT - 10'd1))
            rgb_n = 16'hFFFF;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Hsync       <= ~HS_POL;
            Vsync       <= ~VS_POL;
            Red         <= '0;
            Green       <= '0;
            Blue        <= '0;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else if (pe) begin
            Hsync       <= hs_n;
            Vsync       <= vs_n;
            Red         <= rgb_n[15:11];
            Green       <= rgb_n[10:5];
            Blue        <= rgb_n[4:0];
            de          <= de_n;
            x           <= h_cnt;
            y           <= v_cnt;
            frame_start <= first_px;
        end else begin
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- directed bench for vga_timing_gen.
// dut  : CLK_DIV=2, 42x40 raster (34x34 active), active-low syncs.
// dut1 : CLK_DIV=1, 800-pixel lines, 5-line frame, active-high Hsync.
// Outputs are sampled on the falling clock edge; t counts those samples
// from the one where frame_start is seen (pixel (0,0)).
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode0 = 2'd0, mode1 = 2'd0;
    logic [15:0] solid0 = 16'h0, solid1 = 16'h0;

    logic        hs0, vs0, de0, fs0, hs1, vs1, de1, fs1;
    logic [4:0]  r0, b0, r1, b1;
    logic [5:0]  g0, g1;
    logic [10:0] x0, x1;
    logic [9:0]  y0, y1;

    int asserts = 0;
    int fails   = 0;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(34), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(34), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .CHK_LOG2(5)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode0), .solid_rgb(solid0),
        .Hsync(hs0), .Vsync(vs0), .Red(r0), .Green(g0), .Blue(b0),
        .de(de0), .x(x0), .y(y0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CHK_LOG2(2)
    ) dut1 (
        .clk(clk), .rst(rst), .mode(mode1), .solid_rgb(solid1),
        .Hsync(hs1), .Vsync(vs1), .Red(r1), .Green(g1), .Blue(b1),
        .de(de1), .x(x1), .y(y1), .frame_start(fs1)
    );

    always #5 clk = ~clk;

    function automatic logic sig(input int k);
        case (k)
            0:       return hs0;
            1:       return vs0;
            2:       return hs1;
            default: return vs1;
        endcase
    endfunction

    // Advance until the selected sync reaches lvl; n = samples taken.
    task automatic run_until(input int k, input logic lvl, output int n);
        n = 0;
        while (sig(k) !== lvl && n < 20000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_fs0(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fs0 !== 1'b1 && n < 10000);
        if (fs0 !== 1'b1) begin
            asserts++; fails++;
            $display("FAIL wait_fs0: no frame_start within %0d clks", n);
        end
    endtask

    task automatic wait_fs1(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fs1 !== 1'b1 && n < 10000);
        if (fs1 !== 1'b1) begin
            asserts++; fails++;
            $display("FAIL wait_fs1: no frame_start within %0d clks", n);
        end
    endtask

    task automatic test_reset(input int pre);
        int n, l0, l1;
        if (pre > 0) begin
            wait_fs0(n);
            repeat (pre) @(negedge clk);
            asserts++;
            if (hs0 !== 1'b0) begin
                fails++; $display("FAIL pre_rst_hsync: got %b want 0", hs0);
            end
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        asserts++;
        if ({hs0, vs0, r0, g0, b0, de0, x0, y0, fs0} !==
            {1'b1, 1'b1, 16'h0, 1'b0, 11'd0, 10'd0, 1'b0}) begin
            fails++;
            $display("FAIL rst_out0: got hs=%b vs=%b rgb=%h de=%b x=%0d y=%0d fs=%b",
                     hs0, vs0, {r0, g0, b0}, de0, x0, y0, fs0);
        end
        asserts++;
        if ({hs1, vs1, r1, g1, b1, de1, x1, y1, fs1} !==
            {1'b0, 1'b1, 16'h0, 1'b0, 11'd0, 10'd0, 1'b0}) begin
            fails++;
            $display("FAIL rst_out1: got hs=%b vs=%b rgb=%h de=%b x=%0d y=%0d fs=%b",
                     hs1, vs1, {r1, g1, b1}, de1, x1, y1, fs1);
        end
        rst = 1'b0;
        n = 0; l0 = -1; l1 = -1;
        while ((l0 < 0 || l1 < 0) && n < 20) begin
            @(negedge clk);
            n++;
            if (fs0 === 1'b1 && l0 < 0) l0 = n;
            if (fs1 === 1'b1 && l1 < 0) l1 = n;
        end
        asserts++;
        if (l0 != 2) begin fails++; $display("FAIL rst_fs_lat0: got %0d want 2", l0); end
        asserts++;
        if (l1 != 1) begin fails++; $display("FAIL rst_fs_lat1: got %0d want 1", l1); end
    endtask

    task automatic test_sync();
        int n, w, p;
        wait_fs0(n);
        run_until(0, 1'b0, n);
        run_until(0, 1'b1, w);
        run_until(0, 1'b0, p);
        asserts++;
        if (n != 72) begin fails++; $display("FAIL hs0_start: got %0d want 72", n); end
        asserts++;
        if (w != 8) begin fails++; $display("FAIL hs0_width: got %0d want 8", w); end
        asserts++;
        if (p + w != 84) begin fails++; $display("FAIL hs0_period: got %0d want 84", p + w); end
        wait_fs0(n);
        run_until(1, 1'b0, n);
        run_until(1, 1'b1, w);
        asserts++;
        if (n != 3024) begin fails++; $display("FAIL vs0_start: got %0d want 3024", n); end
        asserts++;
        if (w != 168) begin fails++; $display("FAIL vs0_width: got %0d want 168", w); end
        wait_fs1(n);
        run_until(2, 1'b1, n);
        run_until(2, 1'b0, w);
        run_until(2, 1'b1, p);
        asserts++;
        if (n != 656) begin fails++; $display("FAIL hs1_start: got %0d want 656", n); end
        asserts++;
        if (w != 96) begin fails++; $display("FAIL hs1_width: got %0d want 96", w); end
        asserts++;
        if (p + w != 800) begin fails++; $display("FAIL hs1_period: got %0d want 800", p + w); end
        wait_fs1(n);
        run_until(3, 1'b0, n);
        run_until(3, 1'b1, w);
        asserts++;
        if (n != 2400) begin fails++; $display("FAIL vs1_start: got %0d want 2400", n); end
        asserts++;
        if (w != 800) begin fails++; $display("FAIL vs1_width: got %0d want 800", w); end
    endtask

    task automatic test_frame();
        int n, c;
        wait_fs0(n);
        asserts++;
        if ({x0, y0, de0} !== {11'd0, 10'd0, 1'b1}) begin
            fails++; $display("FAIL fs_pos: got x=%0d y=%0d de=%b want 0 0 1", x0, y0, de0);
        end
        c = 1;
        @(negedge clk);
        asserts++;
        if ({x0, fs0} !== {11'd0, 1'b0}) begin
            fails++; $display("FAIL fs_hold: got x=%0d fs=%b want x=0 fs=0", x0, fs0);
        end
        for (int i = 1; i < 3360; i++) begin
            if (de0 === 1'b1) c++;
            @(negedge clk);
        end
        asserts++;
        if (c != 2312) begin fails++; $display("FAIL de_count: got %0d want 2312", c); end
        asserts++;
        if ({fs0, x0, y0} !== {1'b1, 11'd0, 10'd0}) begin
            fails++; $display("FAIL frame_period0: got fs=%b x=%0d y=%0d want 1 0 0", fs0, x0, y0);
        end
        wait_fs1(n);
        wait_fs1(n);
        asserts++;
        if (n != 4000) begin fails++; $display("FAIL frame_period1: got %0d want 4000", n); end
    endtask

    task automatic test_colour_bars();
        int n, cur, t;
        int bx[13] = '{0, 79, 80, 160, 240, 320, 400, 480, 560, 639, 640, 799, 80};
        int by[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic [15:0] bc[13] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000, 16'h0000,
                                16'h0000, 16'h0000, 16'hFFE0};
        logic de_e;
        mode1 = 2'd1;
        wait_fs1(n);
        cur = 0;
        for (int i = 0; i < 13; i++) begin
            t = by[i] * 800 + bx[i];
            repeat (t - cur) @(negedge clk);
            cur = t;
            de_e = (bx[i] < 640);
            asserts++;
            if ({x1, y1, de1, r1, g1, b1} !== {11'(bx[i]), 10'(by[i]), de_e, bc[i]}) begin
                fails++;
                $display("FAIL bars[%0d]: got x=%0d y=%0d de=%b rgb=%h want x=%0d y=%0d de=%b rgb=%h",
                         i, x1, y1, de1, {r1, g1, b1}, bx[i], by[i], de_e, bc[i]);
            end
        end
        mode1 = 2'd0;
    endtask

    // 34-pixel line: 4-pixel bars, pixels 32/33 are the leftover that must
    // stay in the last (black) bar.
    task automatic test_bar_remainder();
        int n, cur, t;
        int bx[8] = '{0, 3, 4, 27, 28, 32, 33, 4};
        int by[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        logic [15:0] bc[8] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'h001F,
                               16'h0000, 16'h0000, 16'h0000, 16'hFFE0};
        mode0 = 2'd1;
        wait_fs0(n);
        cur = 0;
        for (int i = 0; i < 8; i++) begin
            t = 2 * (by[i] * 42 + bx[i]);
            repeat (t - cur) @(negedge clk);
            cur = t;
            asserts++;
            if ({x0, y0, de0, r0, g0, b0} !== {11'(bx[i]), 10'(by[i]), 1'b1, bc[i]}) begin
                fails++;
                $display("FAIL bar_rem[%0d]: got x=%0d y=%0d de=%b rgb=%h want x=%0d y=%0d de=1 rgb=%h",
                         i, x0, y0, de0, {r0, g0, b0}, bx[i], by[i], bc[i]);
            end
        end
    endtask

    task automatic test_checker();
        int n, cur, t;
        int cx[4] = '{31, 32, 0, 32};
        int cy[4] = '{0, 0, 32, 32};
        logic [15:0] cc[4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
        mode0 = 2'd2;
        wait_fs0(n);
        cur = 0;
        for (int i = 0; i < 4; i++) begin
            t = 2 * (cy[i] * 42 + cx[i]);
            repeat (t - cur) @(negedge clk);
            cur = t;
            asserts++;
            if ({x0, y0, de0, r0, g0, b0} !== {11'(cx[i]), 10'(cy[i]), 1'b1, cc[i]}) begin
                fails++;
                $display("FAIL checker[%0d]: got x=%0d y=%0d de=%b rgb=%h want x=%0d y=%0d de=1 rgb=%h",
                         i, x0, y0, de0, {r0, g0, b0}, cx[i], cy[i], cc[i]);
            end
        end
    endtask

    task automatic test_solid();
        int n;
        wait_fs0(n);
        repeat (20) @(negedge clk);
        mode0  = 2'd3;
        solid0 = 16'hF800;
        repeat (130) @(negedge clk);
        asserts++;
        if ({x0, y0, r0, g0, b0} !== {11'd33, 10'd1, 16'hFFFF}) begin
            fails++;
            $display("FAIL solid_midframe: got x=%0d y=%0d rgb=%h want x=33 y=1 rgb=ffff",
                     x0, y0, {r0, g0, b0});
        end
        wait_fs0(n);
        asserts++;
        if ({fs0, r0, g0, b0} !== {1'b1, 5'h1F, 6'h00, 5'h00}) begin
            fails++;
            $display("FAIL solid_next: got fs=%b R=%h G=%h B=%h want 1 1f 00 00", fs0, r0, g0, b0);
        end
        solid0 = 16'h001F;
        repeat (272) @(negedge clk);
        asserts++;
        if ({x0, y0, r0, g0, b0} !== {11'd10, 10'd3, 16'hF800}) begin
            fails++;
            $display("FAIL solid_held: got x=%0d y=%0d rgb=%h want x=10 y=3 rgb=f800",
                     x0, y0, {r0, g0, b0});
        end
        mode0 = 2'd0;
        wait_fs0(n);
        repeat (440) @(negedge clk);
        asserts++;
        if ({x0, y0, de0, r0, g0, b0} !== {11'd10, 10'd5, 1'b1, 16'h0000}) begin
            fails++;
            $display("FAIL mode0_black: got x=%0d y=%0d de=%b rgb=%h want x=10 y=5 de=1 rgb=0000",
                     x0, y0, de0, {r0, g0, b0});
        end
    endtask

    initial begin
        test_reset(0);
        test_sync();
        test_frame();
        test_colour_bars();
        test_bar_remainder();
        test_checker();
        test_solid();
        test_reset(74);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
